// File: rtl/ccd_pkg.sv
// Shared constants and helpers for the CCD AXI-Stream pipeline (ccd2axis, ccd_black_clamp, rows_resize).
package ccd_pkg;

   localparam int OB_LOG2_DEF   = 4;
   localparam int CNT_WIDTH_DEF = 13;

   // Clamp a signed value into the unsigned range 0 .. 2**width-1.
   function automatic int sat_u(input int value, input int width);
      int max_val;
      max_val = (1 << width) - 1;
      if (value < 0)
         return 0;
      else if (value > max_val)
         return max_val;
      else
         return value;
   endfunction

endpackage

// File: rtl/axis_pipe_reg.sv
// Single-stage AXI-Stream register slice carrying an opaque payload word.
module axis_pipe_reg #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   // A transfer happens when valid & ready are both high at a rising edge; a
   // held output (valid & ~ready) keeps its payload untouched until accepted.
   assign in_ready = ~out_valid | out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_ready) begin
         out_valid <= in_valid;
         if (in_valid)
            out_data <= in_data;
      end
   end

endmodule

// File: rtl/ccd_black_clamp.sv
// Per-line optical-black averaging, black subtraction, pedestal and saturation.
// Optional macro BLACK_IIR_EN smooths the black level across lines with a 1/4 IIR.
module ccd_black_clamp
   import ccd_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int OB_LOG2    = OB_LOG2_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  bypass,
   input  logic [DATA_WIDTH-1:0] pedestal,
   output logic [DATA_WIDTH-1:0] black_level,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);

   localparam int ACC_W = DATA_WIDTH + OB_LOG2;
   localparam int AR_W  = DATA_WIDTH + 2;
   localparam logic [CNT_WIDTH-1:0] OB_LAST = CNT_WIDTH'(2**OB_LOG2 - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                  beat;
   logic [CNT_WIDTH-1:0]  count;
   logic [CNT_WIDTH-1:0]  eff_count;
   logic [ACC_W-1:0]      acc;
   logic [ACC_W-1:0]      acc_base;
   logic [ACC_W-1:0]      acc_sum;
   logic                  in_ob;
   logic                  ob_done;
   logic [DATA_WIDTH-1:0] avg;
   logic [DATA_WIDTH-1:0] level_next;
   logic signed [AR_W-1:0] diff_px;
   logic [DATA_WIDTH-1:0] corrected;

   assign beat = s_axis_tvalid & s_axis_tready;

   // A frame-start pixel restarts the line, even in the middle of one.
   assign eff_count = s_axis_tuser ? '0 : count;
   assign acc_base  = s_axis_tuser ? '0 : acc;
   assign acc_sum   = acc_base + ACC_W'(s_axis_tdata);
   assign in_ob     = (eff_count <= OB_LAST);
   assign ob_done   = (eff_count == OB_LAST);
   assign avg       = acc_sum[ACC_W-1:OB_LOG2];

`ifdef BLACK_IIR_EN
   logic                      level_valid;
   logic signed [DATA_WIDTH:0] level_delta;
   logic signed [DATA_WIDTH:0] level_step;
   logic signed [DATA_WIDTH:0] level_sum;

   assign level_delta = $signed({1'b0, avg}) - $signed({1'b0, black_level});
   assign level_step  = level_delta >>> 2;
   assign level_sum   = $signed({1'b0, black_level}) + level_step;
   assign level_next  = level_valid ? level_sum[DATA_WIDTH-1:0] : avg;
`else
   assign level_next  = avg;
`endif

   // Pixel uses the level in force before this beat, so OB pixels see the previous line's level.
   assign diff_px   = $signed({2'b00, s_axis_tdata}) - $signed({2'b00, black_level})
                    + $signed({2'b00, pedestal});
   assign corrected = bypass ? s_axis_tdata
                             : DATA_WIDTH'(sat_u(int'(diff_px), DATA_WIDTH));

   always_ff @(posedge clk) begin
      if (reset) begin
         count       <= '0;
         acc         <= '0;
         black_level <= '0;
`ifdef BLACK_IIR_EN
         level_valid <= 1'b0;
`endif
      end else if (beat) begin
         if (s_axis_tlast)
            count <= '0;
         else if (eff_count != CNT_MAX)
            count <= eff_count + 1'b1;
         else
            count <= eff_count;

         // Short lines drop their partial sum; a complete OB run consumes it.
         acc <= (in_ob && !ob_done && !s_axis_tlast) ? acc_sum : '0;

         if (ob_done) begin
            black_level <= level_next;
`ifdef BLACK_IIR_EN
            level_valid <= 1'b1;
`endif
         end
      end
   end

   axis_pipe_reg #(
      .WIDTH(DATA_WIDTH + 2)
   ) u_out_reg (
      .clk      (clk),
      .reset    (reset),
      .in_data  ({s_axis_tuser, s_axis_tlast, corrected}),
      .in_valid (s_axis_tvalid),
      .in_ready (s_axis_tready),
      .out_data ({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
      .out_valid(m_axis_tvalid),
      .out_ready(m_axis_tready)
   );

endmodule

// File: tb/tb_ccd_black_clamp.sv
// Randomized self-checking bench for ccd_black_clamp against a line-level reference model.
module tb_ccd_black_clamp;

   localparam int DW  = 8;
   localparam int OBN = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          bypass;
   logic [DW-1:0] pedestal;
   logic [DW-1:0] black_level;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tlast;
   logic          s_axis_tuser;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          m_axis_tuser;
   logic          m_axis_tvalid;
   logic          m_axis_tready;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          last;
      logic          user;
      logic          byp;
      logic [DW-1:0] ped;
   } beat_t;

   beat_t      stim_q[$];
   logic [9:0] exp_q[$];
   int n_total = 0;
   int n_bad   = 0;
   int m_idx, m_sum, m_level;
   bit m_lvl_valid;
   int rdy_mode, vld_mode;

   ccd_black_clamp dut (
      .clk          (clk),
      .reset        (reset),
      .bypass       (bypass),
      .pedestal     (pedestal),
      .black_level  (black_level),
      .s_axis_tdata (s_axis_tdata),
      .s_axis_tlast (s_axis_tlast),
      .s_axis_tuser (s_axis_tuser),
      .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready),
      .m_axis_tdata (m_axis_tdata),
      .m_axis_tlast (m_axis_tlast),
      .m_axis_tuser (m_axis_tuser),
      .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_idx = 0;
      m_sum = 0;
      m_level = 0;
      m_lvl_valid = 0;
      exp_q.delete();
   endtask

   // Reference: mean of the first OBN pixels of each line becomes the level for later pixels.
   task automatic model_beat(input beat_t b);
      int v, px, avg;
      px = int'(b.data);
      if (b.user) begin
         m_idx = 0;
         m_sum = 0;
      end
      if (b.byp) v = px;
      else begin
         v = px - m_level + int'(b.ped);
         if (v < 0) v = 0;
         if (v > 255) v = 255;
      end
      exp_q.push_back({b.user, b.last, v[7:0]});
      if (m_idx < OBN) begin
         m_sum += px;
         if (m_idx == OBN - 1) begin
            avg = m_sum / OBN;
`ifdef BLACK_IIR_EN
            if (m_lvl_valid) m_level = m_level + ((avg - m_level) >>> 2);
            else m_level = avg;
`else
            m_level = avg;
`endif
            m_lvl_valid = 1;
         end
      end
      if (b.last) begin
         m_idx = 0;
         m_sum = 0;
      end else m_idx++;
   endtask

   task automatic push_beat(input int data, input bit last, input bit user, input bit byp, input int ped);
      beat_t b;
      b.data = data[7:0];
      b.last = last;
      b.user = user;
      b.byp  = byp;
      b.ped  = ped[7:0];
      stim_q.push_back(b);
   endtask

   // Line: n_ob pixels of ob_val then n_act pixels of act_val, tlast on the final one.
   task automatic push_line(input int n_ob, input int ob_val, input int n_act, input int act_val,
                            input int ped, input bit user);
      for (int i = 0; i < n_ob + n_act; i++)
         push_beat((i < n_ob) ? ob_val : act_val, i == n_ob + n_act - 1, user && i == 0, 1'b0, ped);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic run(input int budget);
      int c;
      bit presented;
      beat_t cur;
      c = 0;
      presented = 0;
      cur = '0;
      while ((stim_q.size() > 0 || exp_q.size() > 0 || presented) && c < budget) begin
         @(negedge clk);
         c++;
         m_axis_tready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? c[0] : 1'($urandom_range(0, 1));
         if (!presented && stim_q.size() > 0 && (vld_mode == 0 || $urandom_range(0, 3) != 0)) begin
            cur = stim_q.pop_front();
            presented = 1;
         end
         s_axis_tvalid = presented;
         s_axis_tdata  = cur.data;
         s_axis_tlast  = cur.last;
         s_axis_tuser  = cur.user;
         bypass        = cur.byp;
         pedestal      = cur.ped;
         #1;
         if (m_axis_tvalid && m_axis_tready) begin
            if (exp_q.size() == 0) check("extra_out", 1, 0);
            else check("out_beat", {m_axis_tuser, m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
         end
         if (presented && s_axis_tready) begin
            model_beat(cur);
            presented = 0;
         end
      end
      if (stim_q.size() > 0 || exp_q.size() > 0 || presented) begin
         check("timeout", 1, 0);
         stim_q.delete();
         exp_q.delete();
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
   endtask

   initial begin
      int len, ob_base;
      bit usr;
      reset = 1'b1;
      bypass = 1'b0;
      pedestal = '0;
      s_axis_tdata = '0;
      s_axis_tlast = 1'b0;
      s_axis_tuser = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      rdy_mode = 0;
      vld_mode = 0;
      do_reset();
      check("rst_tvalid", m_axis_tvalid, 0);
      check("rst_tdata", m_axis_tdata, 0);
      check("rst_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 0);
      check("rst_level", black_level, 0);

      // Basic OB averaging and subtraction
      push_line(16, 20, 100, 120, 0, 1'b1);
      run(2000);
      check("t1_level", black_level, 20);

      // Reset while an output beat is stalled
      @(negedge clk);
      m_axis_tready = 1'b0;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'd77;
      s_axis_tlast  = 1'b0;
      s_axis_tuser  = 1'b0;
      @(negedge clk);
      s_axis_tvalid = 1'b0;
      check("stall_tvalid", m_axis_tvalid, 1);
      reset = 1'b1;
      @(negedge clk);
      check("midrst_tvalid", m_axis_tvalid, 0);
      check("midrst_tdata", m_axis_tdata, 0);
      check("midrst_level", black_level, 0);
      reset = 1'b0;
      model_reset();
      push_line(16, 30, 4, 50, 0, 1'b0);
      run(500);
      check("after_rst_level", black_level, 30);

      // Saturation low then high
      do_reset();
      push_line(16, 40, 8, 30, 5, 1'b1);
      run(500);
      check("t2_level", black_level, 40);
      do_reset();
      push_line(0, 0, 6, 250, 10, 1'b1);
      run(500);
      check("t2_short_level", black_level, 0);

      // Short line leaves level; full line loads it
      do_reset();
      push_line(16, 8, 4, 60, 0, 1'b1);
      push_line(0, 0, 10, 90, 0, 1'b0);
      run(500);
      check("t3_short_keep", black_level, 8);
      do_reset();
      push_line(0, 0, 10, 90, 0, 1'b1);
      run(500);
      check("t3_short_zero", black_level, 0);
      push_line(16, 8, 5, 40, 0, 1'b0);
      run(500);
      check("t3_full_level", black_level, 8);

      // tuser mid-line at count 7 restarts the OB window
      do_reset();
      for (int i = 0; i < 7; i++) push_beat(200, 1'b0, i == 0, 1'b0, 0);
      for (int i = 0; i < 20; i++) push_beat(i < 16 ? 10 + i : 99, i == 19, i == 0, 1'b0, 0);
      run(500);
      check("t5_level", black_level, 17);

      // Randomized traffic with 1010 backpressure, then random backpressure
      do_reset();
      vld_mode = 1;
      for (int pass = 0; pass < 2; pass++) begin
         rdy_mode = pass + 1;
         for (int ln = 0; ln < 20; ln++) begin
            len = $urandom_range(3, 40);
            ob_base = $urandom_range(0, 60);
            usr = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < len; i++)
               push_beat(i < OBN ? ob_base + $urandom_range(0, 8) : $urandom_range(0, 255),
                         i == len - 1,
                         (usr && i == 0) || (i > 2 && $urandom_range(0, 60) == 0),
                         $urandom_range(0, 7) == 0,
                         $urandom_range(0, 31));
         end
         run(8000);
         check("rand_level", black_level, m_level);
      end
      rdy_mode = 0;
      vld_mode = 0;

`ifdef BLACK_IIR_EN
      // IIR smoothing sequence
      do_reset();
      push_line(16, 64, 4, 100, 0, 1'b1);
      run(500);
      check("iir_first", black_level, 64);
      push_line(16, 0, 4, 100, 0, 1'b0);
      run(500);
      check("iir_48", black_level, 48);
      push_line(16, 0, 4, 100, 0, 1'b0);
      run(500);
      check("iir_36", black_level, 36);
      push_line(16, 0, 4, 100, 0, 1'b0);
      run(500);
      check("iir_27", black_level, 27);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
